// File: rtl/seq_mult_if.sv
// rtl/seq_mult_if.sv - operand/result bundle for the sequential multiplier
interface seq_mult_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             sign;
  logic             start;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output multiplicand, multiplier, sign, start,
    input  hi, lo, busy, done
  );

  modport slave (
    input  multiplicand, multiplier, sign, start,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - radix-2 shift-add multiplier, signed or unsigned operands
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  seq_mult_if.slave   bus
);

  // Counter wide enough to hold WIDTH-1; a 1-bit counter covers WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;   // |A|, held for the whole operation
  logic [WIDTH-1:0]   r_acc;     // upper half of the product register
  logic [WIDTH-1:0]   r_mq;      // lower half: multiplier bits shift out, product bits shift in
  logic               r_neg;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_neg;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_result;

  // Magnitudes: the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    w_abs_a = bus.multiplicand;
    w_abs_b = bus.multiplier;
    if (bus.sign && bus.multiplicand[WIDTH-1]) begin
      w_abs_a = (~bus.multiplicand) + {{(WIDTH-1){1'b0}}, 1'b1};
    end
    if (bus.sign && bus.multiplier[WIDTH-1]) begin
      w_abs_b = (~bus.multiplier) + {{(WIDTH-1){1'b0}}, 1'b1};
    end
    w_neg = bus.sign & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
  end

  // One shift-add step: the carry out of acc+|A| becomes the new acc MSB after the shift.
  always_comb begin
    w_addend = r_mq[0] ? {1'b0, r_mcand} : '0;
    w_sum    = {1'b0, r_acc} + w_addend;
  end

  // Sign is applied once at the output; negating zero yields zero, so no -0 artifact.
  always_comb begin
    w_prod   = {r_acc, r_mq};
    w_result = r_neg ? ((~w_prod) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_prod;
  end

  assign bus.hi   = w_result[2*WIDTH-1:WIDTH];
  assign bus.lo   = w_result[WIDTH-1:0];
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // Control FSM and datapath; start wins in any state, including mid-operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.start) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_mcand <= w_abs_a;
      r_acc   <= '0;
      r_mq    <= w_abs_b;
      r_neg   <= w_neg;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_acc <= w_sum[WIDTH:1];
          r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - directed scoreboard bench for seq_mult
module tb_seq_mult;

  localparam int W = 32;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;
  logic [2*W-1:0] sb_q[$];

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Pulses start for one edge, then scrambles the operand inputs to show they are ignored.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    @(posedge clock);
    #1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.sign         = s;
    bus.start        = 1'b1;
    if (push) sb_q.push_back(model(a, b, s));
    @(posedge clock);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    bus.sign         = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(input string tag);
    int          busy_cyc;
    int          got;
    logic [63:0] exp;
    busy_cyc = 0;
    got      = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(negedge clock);
      if (bus.done) got = 1;
      else if (bus.busy) busy_cyc++;
    end
    check_int({tag, "_done_seen"}, got, 1);
    check_int({tag, "_busy_cycles"}, busy_cyc, W);
    check_int({tag, "_sb_nonempty"}, sb_q.size(), 1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'h0;
    check64({tag, "_hi"}, {32'h0, bus.hi}, {32'h0, exp[63:32]});
    check64({tag, "_lo"}, {32'h0, bus.lo}, {32'h0, exp[31:0]});
    @(negedge clock);
    check_int({tag, "_done_pulse_1cyc"}, int'(bus.done), 0);
    check64({tag, "_held"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    int dn;
    n_total          = 0;
    n_bad            = 0;
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.sign         = 1'b0;

    repeat (2) @(negedge clock);
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_done", int'(bus.done), 0);
    check64("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    reset = 1'b1;

    repeat (3) @(negedge clock);
    check_int("idle_busy", int'(bus.busy), 0);
    check_int("idle_done", int'(bus.done), 0);

    start_op(32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 1);
    wait_result("s_m7x3");
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
    wait_result("u_max");
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
    wait_result("s_m1xm1");
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1);
    wait_result("s_minxmin");
    start_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1);
    wait_result("s_minx1");
    start_op(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 1);
    wait_result("s_0xm5");
    for (int k = 0; k < 4; k++) begin
      start_op($urandom, $urandom, 1'(k & 1), 1);
      wait_result($sformatf("rand%0d", k));
    end

    // Restart: the first operation must never report completion.
    start_op(32'd3, 32'd4, 1'b0, 0);
    dn = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.done) dn++;
    end
    start_op(32'd5, 32'd6, 1'b0, 1);
    check_int("restart_no_early_done", dn, 0);
    wait_result("restart");

    // Reset in the middle of an operation.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    repeat (13) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_int("midrst_busy", int'(bus.busy), 0);
    check_int("midrst_done", int'(bus.done), 0);
    check64("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
    repeat (2) @(negedge clock);
    reset            = 1'b1;
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd9;
    bus.sign         = 1'b0;
    bus.start        = 1'b1;
    sb_q.push_back(model(32'd2, 32'd9, 1'b0));
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_result("post_rst");

    repeat (3) @(negedge clock);
    check_int("final_idle_done", int'(bus.done), 0);
    check_int("final_idle_busy", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
